// File: rtl/bpf_alu_seq.sv
// Three-state sequencer that issues one BPF-style instruction to an external combinational ALU.
// Optional macro BPF_SEQ_DIVZERO_EN: forces A to 0 and sets a sticky err when dividing by zero.
module bpf_alu_seq #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_cls,
    input  logic [CW-1:0] in_op,
    input  logic          in_src,
    input  logic [W-1:0]  in_k,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [CW-1:0] alu_ctl,
    input  logic [W-1:0]  alu_out,
    output logic [W-1:0]  acc,
    output logic [W-1:0]  xreg,
    output logic          done,
    output logic          zero,
    output logic [7:0]    retired,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_LD  = 2'd1;
    localparam logic [1:0] CLS_TAX = 2'd2;
    localparam logic [1:0] CLS_TXA = 2'd3;

    state_t          state_q, state_d;
    logic [1:0]      cls_q;
    logic [CW-1:0]   op_q;
    logic            src_q;
    logic [W-1:0]    k_q;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    x_q, x_d;
    logic [7:0]      ret_q;
    logic            accept;

    assign accept = (state_q == IDLE) && in_valid;

`ifdef BPF_SEQ_DIVZERO_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        x_d      = x_q;
        in_ready = 1'b0;
        done     = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctl  = '0;
`ifdef BPF_SEQ_DIVZERO_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = EXEC;
            end
            EXEC: begin
                state_d = DONE;
                if (cls_q == CLS_ALU) begin
                    alu_a   = acc_q;
                    alu_b   = src_q ? x_q : k_q;
                    alu_ctl = op_q;
                end
                case (cls_q)
                    CLS_ALU: begin
                        acc_d = alu_out;
`ifdef BPF_SEQ_DIVZERO_EN
                        // Divide by zero: the ALU result is meaningless, so clear A and flag it.
                        if (op_q == CW'(3) && alu_b == '0) begin
                            acc_d = '0;
                            err_d = 1'b1;
                        end
`endif
                    end
                    CLS_LD:  acc_d = k_q;
                    CLS_TAX: x_d   = acc_q;
                    CLS_TXA: acc_d = x_q;
                    default: acc_d = acc_q;
                endcase
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cls_q   <= '0;
            op_q    <= '0;
            src_q   <= 1'b0;
            k_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            if (accept) begin
                cls_q <= in_cls;
                op_q  <= in_op;
                src_q <= in_src;
                k_q   <= in_k;
            end
            if (state_q == DONE) ret_q <= ret_q + 8'd1;
        end
    end

`ifdef BPF_SEQ_DIVZERO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign acc     = acc_q;
    assign xreg    = x_q;
    assign zero    = (acc_q == '0);
    assign retired = ret_q;

endmodule

// File: doc/bpf_alu_seq.md
BPF_ALU_SEQ -- requirements
Module: bpf_alu_seq

Interface
REQ-001 Parameter W, default 8: datapath width of A, X, K and the alu operands.
REQ-002 Parameter CW, default 4: alu control width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  instruction offered.
REQ-006 in_ready  output  1  sequencer can accept an instruction.
REQ-007 in_cls  input  2  class: 0=ALU, 1=LD imm (A<=K), 2=TAX (X<=A), 3=TXA (A<=X).
REQ-008 in_op  input  CW  alu control code; used only when in_cls=0.
REQ-009 in_src  input  1  second alu operand: 0=K, 1=X.
REQ-010 in_k  input  W  immediate K.
REQ-011 alu_a  output  W  alu operand a.
REQ-012 alu_b  output  W  alu operand b.
REQ-013 alu_ctl  output  CW  alu control.
REQ-014 alu_out  input  W  combinational alu result.
REQ-015 acc  output  W  accumulator A.
REQ-016 xreg  output  W  index register X.
REQ-017 done  output  1  one-cycle retire pulse.
REQ-018 zero  output  1  acc==0, combinational from A.
REQ-019 retired  output  8  retired-instruction count.
REQ-020 err  output  1  sticky divide-by-zero flag (see Configuration).

Function
REQ-021 The FSM shall have exactly the states IDLE, EXEC and DONE.
REQ-022 in_ready shall be 1 only in IDLE.
REQ-023 IDLE->EXEC on an edge with in_valid=1; in_cls, in_op, in_src and in_k are latched at that edge.
REQ-024 in_valid is ignored while in_ready=0, and no instruction is queued.
REQ-025 EXEC: alu_a=A; alu_b=K if src=0, else X; alu_ctl=latched op; these shall hold for the whole EXEC cycle.
REQ-026 Outside EXEC, and in EXEC for non-ALU classes: alu_a, alu_b and alu_ctl shall be 0.
REQ-027 EXEC->DONE unconditionally.
- The same edge writes the destination: ALU A<=alu_out; LD A<=K; TAX X<=A; TXA A<=X.
REQ-028 DONE: done=1 for exactly that cycle; retired increments at the DONE->IDLE edge.
REQ-029 DONE->IDLE unconditionally.
- Latency: accept edge E0, register write E1, done high E1..E2, in_ready high after E2.
- Throughput: one instruction per 3 cycles.
REQ-030 retired shall wrap 255->0 with no flag.
REQ-031 All arithmetic is W bits; alu_out is taken as-is, with no extension or saturation.
REQ-032 in_valid held high in DONE shall be accepted at the first IDLE edge, not earlier.

Reset
REQ-033 On rst=1, state shall be IDLE regardless of clk.
- acc, xreg, retired, err and done are 0; alu_a, alu_b and alu_ctl are 0; in_ready=1 after release.
REQ-034 Reset asserted in EXEC or DONE shall discard the instruction.
- No done pulse.
- No register write.
- No retired increment.
REQ-035 The first accept after reset release needs in_valid at a rising edge with rst=0.

Configuration
REQ-036 Macro BPF_SEQ_DIVZERO_EN.
- Defined: in EXEC, for in_cls=0, alu_ctl=4'h3 (divide) and alu_b=0:
  - A<=0 instead of alu_out.
  - err<=1, sticky until reset.
  - done and retired behave normally.
- Not defined: divide goes through alu_out like any other op, and err is tied to 0.

Verification
REQ-037 Load then ALU op.
- Stimulus: LD k=20; then ALU op=4 src=K k=4.
- Required: during EXEC alu_a=20, alu_b=4, alu_ctl=4; at E1 acc=alu_out; done pulses once; retired=2.
REQ-038 Register moves.
- Stimulus: LD 7; TAX; LD 0; TXA.
- Required: xreg=7; zero=1 after LD 0; acc=7 after TXA; retired=4.
REQ-039 Back-pressure.
- Stimulus: in_valid held high continuously with changing in_k.
- Required: accepts only on IDLE edges, one per 3 cycles; in_k changes in EXEC/DONE do not affect the result.
REQ-040 Reset mid-operation.
- Stimulus: rst asserted mid-EXEC, asynchronous, between edges.
- Required: outputs go to 0 immediately; no done pulse; retired unchanged at 0.
REQ-041 Counter wrap.
- Stimulus: 256 LD instructions.
- Required: retired returns to 0.
REQ-042 Divide by zero.
- Stimulus: with BPF_SEQ_DIVZERO_EN defined, ALU op=3 src=X while xreg=0.
- Required: acc=0 and err=1, holding through later instructions.
- Without the macro: acc=alu_out and err=0.
